// File: rtl/cprv_lsu_mem_ctrl.sv
// cprv_lsu_mem_ctrl
//   Load/store front-end for an RV64 core. It accepts one request at a time
//   and turns it into word-wide transactions on a valid/ready single-port RAM
//   (1-cycle read latency, no byte mask). Sub-doubleword stores are done as a
//   read-modify-write. Load data is extracted from the word and sign- or
//   zero-extended. Misaligned requests are answered with an error and never
//   reach the RAM.
//
// Ports
//   clk, rst                 clock / asynchronous active-high reset
//   req_*                    request channel (valid/ready), byte address,
//                            size (0=B 1=H 2=W 3=D), unsigned flag, store data
//   rsp_*                    response channel, held until rsp_ready_i
//   mem_valid_o/ready_i      RAM request channel (w_en, word address, wdata)
//   mem_valid_i/ready_o      RAM response channel (ready tied high), rdata
//
// DATA_WIDTH must equal XLEN; the datapath is written in terms of XLEN.

module cprv_lsu_mem_ctrl #(
  parameter int XLEN       = 64,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [XLEN-1:0]       req_addr_i,
  input  logic [XLEN-1:0]       req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [XLEN-1:0]       rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  mem_valid_o,
  input  logic                  mem_ready_i,
  output logic                  mem_w_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_valid_i,
  output logic                  mem_ready_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RESP
  } state_t;

  state_t          state;
  logic            we_q;
  logic [1:0]      size_q;
  logic            uns_q;
  logic [2:0]      off_q;
  logic [XLEN-1:0] wdata_q;

  // Address bits above the RAM word address are intentionally ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr_i[XLEN-1:ADDR_WIDTH+3];

  // The RAM response channel is always drained.
  assign mem_ready_o = 1'b1;
  assign req_ready_o = (state == IDLE);

  // Right-aligned byte-lane mask for an access size.
  function automatic logic [XLEN-1:0] size_mask(input logic [1:0] sz);
    logic [XLEN-1:0] m;
    case (sz)
      2'd0:    m = {{(XLEN-8){1'b0}},  8'hFF};
      2'd1:    m = {{(XLEN-16){1'b0}}, 16'hFFFF};
      2'd2:    m = {{(XLEN-32){1'b0}}, 32'hFFFF_FFFF};
      default: m = {XLEN{1'b1}};
    endcase
    return m;
  endfunction

  function automatic logic misaligned(input logic [1:0] sz, input logic [2:0] a);
    logic r;
    case (sz)
      2'd1:    r = a[0];
      2'd2:    r = |a[1:0];
      2'd3:    r = |a[2:0];
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Datapath on the returning RAM word, using the latched request.
  logic [5:0]      shamt;
  logic [XLEN-1:0] field;
  logic [XLEN-1:0] ld_ext;
  logic [XLEN-1:0] wmask;
  logic [XLEN-1:0] merged;

  assign shamt  = {off_q, 3'b000};
  assign field  = mem_rdata_i >> shamt;
  assign wmask  = size_mask(size_q) << shamt;
  assign merged = (mem_rdata_i & ~wmask) | ((wdata_q << shamt) & wmask);

  // Sign bit is forced to zero for unsigned loads, giving zero-extension.
  always_comb begin
    ld_ext = field;
    case (size_q)
      2'd0:    ld_ext = {{(XLEN-8){~uns_q & field[7]}},   field[7:0]};
      2'd1:    ld_ext = {{(XLEN-16){~uns_q & field[15]}}, field[15:0]};
      2'd2:    ld_ext = {{(XLEN-32){~uns_q & field[31]}}, field[31:0]};
      default: ld_ext = field;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      size_q      <= 2'd0;
      uns_q       <= 1'b0;
      off_q       <= 3'd0;
      wdata_q     <= '0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
      mem_valid_o <= 1'b0;
      mem_w_en_o  <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            we_q       <= req_we_i;
            size_q     <= req_size_i;
            uns_q      <= req_unsigned_i;
            off_q      <= req_addr_i[2:0];
            wdata_q    <= req_wdata_i;
            mem_addr_o <= req_addr_i[ADDR_WIDTH+2:3];
            if (misaligned(req_size_i, req_addr_i[2:0])) begin
              // Answer directly, no RAM traffic.
              state       <= RESP;
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= 1'b1;
              rsp_rdata_o <= '0;
            end else if (req_we_i && req_size_i == 2'd3) begin
              // Full-word store needs no read.
              state       <= WR_REQ;
              mem_valid_o <= 1'b1;
              mem_w_en_o  <= 1'b1;
              mem_wdata_o <= req_wdata_i;
            end else begin
              // Loads and partial stores both start with a read.
              state       <= RD_REQ;
              mem_valid_o <= 1'b1;
              mem_w_en_o  <= 1'b0;
            end
          end
        end
        RD_REQ: begin
          if (mem_ready_i) begin
            mem_valid_o <= 1'b0;
            state       <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (mem_valid_i) begin
            if (we_q) begin
              // Second half of read-modify-write; address is still latched.
              state       <= WR_REQ;
              mem_valid_o <= 1'b1;
              mem_w_en_o  <= 1'b1;
              mem_wdata_o <= merged;
            end else begin
              state       <= RESP;
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= 1'b0;
              rsp_rdata_o <= ld_ext;
            end
          end
        end
        WR_REQ: begin
          if (mem_ready_i) begin
            mem_valid_o <= 1'b0;
            mem_w_en_o  <= 1'b0;
            state       <= WR_WAIT;
          end
        end
        WR_WAIT: begin
          if (mem_valid_i) begin
            state       <= RESP;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= '0;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            state       <= IDLE;
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cprv_lsu_mem_ctrl.sv
`timescale 1ns/1ps
// Bench for cprv_lsu_mem_ctrl: a behavioural 1-cycle-latency RAM, a byte-array
// reference memory, directed scenarios followed by randomized requests.
module tb_cprv_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [1:0]  req_size_i = 2'd0;
  logic        req_unsigned_i = 1'b0;
  logic [63:0] req_addr_i = '0;
  logic [63:0] req_wdata_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b1;
  logic [63:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        mem_valid_o;
  logic        mem_ready_i = 1'b1;
  logic        mem_w_en_o;
  logic [11:0] mem_addr_o;
  logic [63:0] mem_wdata_o;
  logic        mem_valid_i = 1'b0;
  logic        mem_ready_o;
  logic [63:0] mem_rdata_i = '0;

  cprv_lsu_mem_ctrl #(.XLEN(64), .DATA_WIDTH(64), .ADDR_WIDTH(12)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_w_en_o(mem_w_en_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_valid_i(mem_valid_i), .mem_ready_o(mem_ready_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  // RAM model: handshake at an edge, response one cycle later. Not reset,
  // so a request taken just before a reset still answers afterwards.
  logic [63:0] ram [0:4095];
  logic        bd_we = 1'b0;
  logic [11:0] bd_idx = '0;
  logic [63:0] bd_val = '0;
  int          rd_hs = 0;
  int          wr_hs = 0;

  always @(posedge clk) begin
    mem_valid_i <= 1'b0;
    if (bd_we) ram[bd_idx] <= bd_val;
    if (mem_valid_o && mem_ready_i) begin
      mem_valid_i <= 1'b1;
      mem_rdata_i <= ram[mem_addr_o];
      if (mem_w_en_o) begin
        ram[mem_addr_o] <= mem_wdata_o;
        wr_hs <= wr_hs + 1;
      end else begin
        rd_hs <= rd_hs + 1;
      end
    end
  end

  // Reference memory as plain bytes (addresses 0..0x7FF used).
  logic [7:0] ref_mem [0:2047];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_word(input int idx);
    logic [63:0] v = '0;
    for (int i = 0; i < 8; i++) v = v | (64'(ref_mem[idx*8+i]) << (8*i));
    return v;
  endfunction

  function automatic logic [63:0] ref_load(input logic [63:0] a, input logic [1:0] sz, input logic uns);
    int n = 1 << sz;
    int b = int'(a[10:0]);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v = v | (64'(ref_mem[b+i]) << (8*i));
    if (!uns && sz != 2'd3 && v[8*n-1]) v = v - (64'd1 << (8*n));
    return v;
  endfunction

  task automatic ref_store(input logic [63:0] a, input logic [1:0] sz, input logic [63:0] wd);
    int n = 1 << sz;
    int b = int'(a[10:0]);
    for (int i = 0; i < n; i++) ref_mem[b+i] = wd[8*i +: 8];
  endtask

  task automatic set_word(input int idx, input logic [63:0] val);
    for (int i = 0; i < 8; i++) ref_mem[idx*8+i] = val[8*i +: 8];
    bd_we = 1'b1; bd_idx = 12'(idx); bd_val = val;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  task automatic drive(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [63:0] a, input logic [63:0] wd);
    req_valid_i = 1'b1; req_we_i = we; req_size_i = sz;
    req_unsigned_i = uns; req_addr_i = a; req_wdata_i = wd;
  endtask

  // One complete request: latency, response, RAM traffic and memory contents.
  task automatic do_req(input string tag, input logic we, input logic [1:0] sz,
                        input logic uns, input logic [63:0] a, input logic [63:0] wd,
                        input int mstall, input int rstall);
    int n, lat, exp_lat, rd0, wr0, widx, exp_rd_hs, exp_wr_hs;
    logic mis;
    logic [63:0] exp_rd, cap_rd;
    logic cap_err;
    logic [11:0] cap_addr;
    n = 1 << sz;
    mis = (int'(a[2:0]) % n) != 0;
    widx = int'(a[10:3]);
    exp_rd = (we || mis) ? 64'd0 : ref_load(a, sz, uns);
    if (mis) exp_lat = 1;
    else if (!we || sz == 2'd3) exp_lat = 3 + mstall;
    else exp_lat = 5 + mstall;
    if (mis) mstall = 0;
    exp_rd_hs = (mis || (we && sz == 2'd3)) ? 0 : 1;
    exp_wr_hs = (!mis && we) ? 1 : 0;
    rd0 = rd_hs; wr0 = wr_hs;
    chk({tag, " ready"}, 64'(req_ready_o), 64'd1);
    drive(we, sz, uns, a, wd);
    mem_ready_i = (mstall == 0);
    rsp_ready_i = (rstall == 0);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    lat = 1;
    if (mstall > 0) begin
      cap_addr = mem_addr_o;
      chk({tag, " mem_addr"}, 64'(mem_addr_o), 64'(a[14:3]));
      for (int k = 0; k < mstall; k++) begin
        chk({tag, " mem_valid held"}, 64'(mem_valid_o), 64'd1);
        chk({tag, " mem_addr held"}, 64'(mem_addr_o), 64'(cap_addr));
        @(posedge clk); #1;
        lat++;
      end
      mem_ready_i = 1'b1;
    end
    while (rsp_valid_o !== 1'b1 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " rdata"}, rsp_rdata_o, exp_rd);
    chk({tag, " err"}, 64'(rsp_err_o), 64'(mis));
    cap_rd = rsp_rdata_o; cap_err = rsp_err_o;
    for (int k = 0; k < rstall; k++) begin
      @(posedge clk); #1;
      chk({tag, " rsp_valid held"}, 64'(rsp_valid_o), 64'd1);
      chk({tag, " rdata held"}, rsp_rdata_o, cap_rd);
      chk({tag, " err held"}, 64'(rsp_err_o), 64'(cap_err));
    end
    rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    chk({tag, " rsp done"}, 64'(rsp_valid_o), 64'd0);
    chk({tag, " read count"}, 64'(rd_hs - rd0), 64'(exp_rd_hs));
    chk({tag, " write count"}, 64'(wr_hs - wr0), 64'(exp_wr_hs));
    if (we && !mis) begin
      ref_store(a, sz, wd);
      chk({tag, " ram word"}, ram[widx], ref_word(widx));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values while reset is held.
    #1;
    chk("reset rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("reset rsp_err", 64'(rsp_err_o), 64'd0);
    chk("reset rsp_rdata", rsp_rdata_o, 64'd0);
    chk("reset mem_valid", 64'(mem_valid_o), 64'd0);
    chk("reset mem_w_en", 64'(mem_w_en_o), 64'd0);
    chk("reset mem_addr", 64'(mem_addr_o), 64'd0);
    chk("reset mem_wdata", mem_wdata_o, 64'd0);
    chk("reset req_ready", 64'(req_ready_o), 64'd1);
    chk("mem_ready tied", 64'(mem_ready_o), 64'd1);
    @(posedge clk); #1;
    for (int i = 0; i < 256; i++) set_word(i, {$urandom, $urandom});
    rst = 1'b0;
    @(posedge clk); #1;

    // T1/T2: word load and extraction variants.
    set_word(2, 64'h8877665544332211);
    do_req("T1 LD 0x10", 1'b0, 2'd3, 1'b0, 64'h10, 64'd0, 0, 0);
    chk("T1 const", ref_load(64'h10, 2'd3, 1'b0), 64'h8877665544332211);
    do_req("T2 LB 0x17", 1'b0, 2'd0, 1'b0, 64'h17, 64'd0, 0, 0);
    do_req("T2 LBU 0x17", 1'b0, 2'd0, 1'b1, 64'h17, 64'd0, 0, 0);
    do_req("T2 LH 0x12", 1'b0, 2'd1, 1'b0, 64'h12, 64'd0, 0, 0);
    do_req("T2 LW 0x14", 1'b0, 2'd2, 1'b0, 64'h14, 64'd0, 0, 0);
    do_req("T2 LWU 0x14", 1'b0, 2'd2, 1'b1, 64'h14, 64'd0, 0, 0);

    // T3: halfword read-modify-write.
    set_word(1, 64'h8877665544332211);
    do_req("T3 SH 0x0A", 1'b1, 2'd1, 1'b0, 64'h0A, 64'hBEEF, 0, 0);
    chk("T3 merged word", ram[1], 64'h88776655BEEF2211);

    // T4: misaligned, including the other sizes.
    do_req("T4 LW 0x06", 1'b0, 2'd2, 1'b0, 64'h06, 64'd0, 0, 0);
    do_req("T4 SD 0x0C", 1'b1, 2'd3, 1'b0, 64'h0C, 64'h1234, 0, 0);
    do_req("T4 LH 0x03", 1'b0, 2'd1, 1'b1, 64'h03, 64'd0, 0, 0);

    // T5: stalls on both channels.
    do_req("T5 LD stall", 1'b0, 2'd3, 1'b0, 64'h10, 64'd0, 5, 3);
    do_req("T5 SB stall", 1'b1, 2'd0, 1'b0, 64'h2D, 64'hA5, 2, 2);

    // T6a: reset while a write request is pending (never handshaked).
    set_word(4, 64'h0123456789ABCDEF);
    mem_ready_i = 1'b0;
    drive(1'b1, 2'd3, 1'b0, 64'h20, 64'hDEADBEEFCAFEF00D);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    chk("T6a in WR_REQ", 64'(mem_valid_o), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1; #1;
    chk("T6a mem_valid", 64'(mem_valid_o), 64'd0);
    chk("T6a req_ready", 64'(req_ready_o), 64'd1);
    chk("T6a rsp_valid", 64'(rsp_valid_o), 64'd0);
    #1;
    rst = 1'b0;
    mem_ready_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("T6a ram untouched", ram[4], ref_word(4));

    // T6b: reset while a read is in flight; its orphan response must be dropped.
    set_word(5, 64'h5555AAAA5555AAAA);
    set_word(6, 64'h6666777788889999);
    drive(1'b0, 2'd3, 1'b0, 64'h28, 64'd0);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; #1;
    rst = 1'b0;
    do_req("T6b LD after rst", 1'b0, 2'd3, 1'b0, 64'h30, 64'd0, 0, 0);

    // T6c: reset after the write handshake; the write stands.
    drive(1'b1, 2'd3, 1'b0, 64'h38, 64'hFEEDFACE12345678);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; #1;
    rst = 1'b0;
    ref_store(64'h38, 2'd3, 64'hFEEDFACE12345678);
    @(posedge clk); #1;
    chk("T6c ram committed", ram[7], ref_word(7));
    chk("T6c idle", 64'(req_ready_o), 64'd1);
    do_req("T6c LD back", 1'b0, 2'd3, 1'b0, 64'h38, 64'd0, 0, 0);

    // Randomized requests; upper address bits are junk that must be ignored.
    for (int t = 0; t < 60; t++) begin
      logic        we, uns;
      logic [1:0]  sz;
      logic [63:0] lo, hi, a, wd;
      int          n;
      we  = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      sz  = 2'($urandom_range(0, 3));
      n   = 1 << sz;
      lo  = 64'($urandom_range(0, 2047));
      if ($urandom_range(0, 3) != 0) lo = lo & ~64'(n - 1);
      hi  = {$urandom, $urandom};
      a   = (hi << 15) | lo;
      wd  = {$urandom, $urandom};
      do_req($sformatf("rand%0d", t), we, sz, uns, a, wd,
             int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
